// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the R-type issue sequencer.
// The package holds the FSM state encoding, the opcode constants and the default halt sentinel.
package mips_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam logic [5:0]  OPCODE_RTYPE      = 6'b000000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    function automatic logic is_rtype(input logic [31:0] word);
        return (word[31:26] == OPCODE_RTYPE);
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// Instruction store: DEPTH x 32 words, one synchronous write port and one combinational read port.
// Contents are deliberately not reset so a loaded program survives a sequencer reset.
module instr_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rtype_issue_sequencer.sv
// Issue engine that drives the single-cycle R-type datapath from a loaded program:
// each instruction is held for SETTLE_CYCLES cycles, then committed with a one-cycle reg_we strobe.
module rtype_issue_sequencer
    import mips_seq_pkg::*;
#(
    parameter int          DEPTH         = 16,
    parameter int          AW            = 4,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] HALT_WORD     = HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   instruction_set,
    output logic          instr_valid,
    output logic          reg_we,
    input  logic [31:0]   result,
    output logic [31:0]   last_result,
    output logic [AW:0]   issued_count,
    output logic [AW:0]   illegal_count,
    output logic          busy,
    output logic          done
);

    localparam int SW = 4;

    seq_state_t    state_r;
    logic [AW:0]   pc_r;
    logic [AW:0]   len_r;
    logic [SW-1:0] settle_cnt_r;

    logic          buf_we_s;
    logic [31:0]   rd_word_s;
    logic [AW:0]   pc_next_s;
    logic [AW:0]   len_clamp_s;

    instr_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_r[AW-1:0]),
        .rdata (rd_word_s)
    );

    // Buffer write gating, next pc and program-length clamp
    always_comb begin
        buf_we_s  = load_en && (state_r == IDLE);
        pc_next_s = pc_r + (AW+1)'(1);
        if (prog_len > (AW+1)'(DEPTH)) begin
            len_clamp_s = (AW+1)'(DEPTH);
        end else begin
            len_clamp_s = prog_len;
        end
    end

    // Sequencer FSM with registered strobes, counters and datapath outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            pc_r            <= '0;
            len_r           <= '0;
            settle_cnt_r    <= '0;
            instruction_set <= 32'd0;
            instr_valid     <= 1'b0;
            reg_we          <= 1'b0;
            last_result     <= 32'd0;
            issued_count    <= '0;
            illegal_count   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            done   <= 1'b0;
            // Abort wins over everything, including a commit launched in the same cycle
            if (abort && (state_r != IDLE)) begin
                state_r     <= IDLE;
                instr_valid <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (prog_len == (AW+1)'(0)) begin
                                done <= 1'b1;
                            end else begin
                                len_r         <= len_clamp_s;
                                pc_r          <= '0;
                                issued_count  <= '0;
                                illegal_count <= '0;
                                busy          <= 1'b1;
                                state_r       <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (rd_word_s == HALT_WORD) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else if (!is_rtype(rd_word_s)) begin
                            illegal_count <= illegal_count + (AW+1)'(1);
                            pc_r          <= pc_next_s;
                            if (pc_next_s == len_r) begin
                                done    <= 1'b1;
                                state_r <= DONE;
                            end
                        end else begin
                            instruction_set <= rd_word_s;
                            instr_valid     <= 1'b1;
                            settle_cnt_r    <= SW'(SETTLE_CYCLES - 1);
                            state_r         <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_r == SW'(0)) begin
                            reg_we  <= 1'b1;
                            state_r <= COMMIT;
                        end else begin
                            settle_cnt_r <= settle_cnt_r - SW'(1);
                        end
                    end
                    COMMIT: begin
                        last_result  <= result;
                        issued_count <= issued_count + (AW+1)'(1);
                        pc_r         <= pc_next_s;
                        if (pc_next_s == len_r) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end
                    DONE: begin
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end
                    default: begin
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtype_issue_sequencer.sv
// Self-checking bench: a timeline model derives per-cycle expectations for each run,
// one negedge process compares the DUT against it, and literal checks pin the model.
module tb_rtype_issue_sequencer;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam int          S     = 2;
    localparam int          MAXC  = 80;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    localparam logic [31:0] L1 = 32'h0003_D0E0;   // add r0,r3 -> 0x103
    localparam logic [31:0] L2 = 32'h0023_B8C2;   // srl r3 by 3 -> 0x0
    localparam logic [31:0] L3 = 32'h00A7_E0E0;   // add r5,r7 -> 0x10C
    localparam logic [31:0] L4 = 32'h00E4_1025;   // or r7,r4 -> 0x107
    localparam logic [31:0] BAD = 32'h8C00_0000;

    logic          clk = 1'b0;
    logic          reset, load_en, start, abort;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic [31:0]   instruction_set, result, last_result;
    logic          instr_valid, reg_we, busy, done;
    logic [AW:0]   issued_count, illegal_count;

    always #5 clk = ~clk;

    rtype_issue_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .SETTLE_CYCLES(S), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .abort(abort),
        .instruction_set(instruction_set), .instr_valid(instr_valid), .reg_we(reg_we),
        .result(result), .last_result(last_result), .issued_count(issued_count),
        .illegal_count(illegal_count), .busy(busy), .done(done)
    );

    // Toy R-type core: rs reads as 0x100+index, rt reads as its index
    function automatic logic [31:0] core_model(input logic [31:0] w);
        logic [31:0] a, b, r;
        a = 32'h100 + {27'd0, w[25:21]};
        b = {27'd0, w[20:16]};
        case (w[5:0])
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h2A:   r = (a < b) ? 32'd1 : 32'd0;
            6'h00:   r = b << w[10:6];
            6'h02:   r = b >> w[10:6];
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    always_comb result = core_model(instruction_set);

    int n_checks = 0;
    int n_err    = 0;
    int drv_cyc  = 0;
    bit chk_en   = 1'b0;
    int we_seen;
    int dut_done_c;
    bit forbid_en = 1'b0;
    logic [31:0] forbid_word;
    int forbid_hits;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last = 32'd0;
    int model_issued  = 0;
    int model_illegal = 0;

    bit          exp_we   [MAXC+1];
    bit          exp_done [MAXC+1];
    bit          exp_busy [MAXC+1];
    bit          exp_iv   [MAXC+1];
    logic [31:0] exp_word [MAXC+1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, drv_cyc, act, expv);
        end
    endtask

    // Timeline model: ISSUE takes a cycle, a legal word is then shown S cycles and committed next
    task automatic build_trace(input int plen, input int abort_c, output int end_c);
        int len, t, done_c;
        logic [31:0] w;
        for (int c = 0; c <= MAXC; c++) begin
            exp_we[c] = 1'b0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_iv[c] = 1'b0; exp_word[c] = 32'd0;
        end
        if (plen == 0) begin
            exp_done[1] = 1'b1;
            end_c = 3;
            return;
        end
        len = (plen > DEPTH) ? DEPTH : plen;
        model_issued = 0;
        model_illegal = 0;
        t = 1;
        for (int k = 0; k < len; k++) begin
            w = model_mem[k];
            if (w == HALT) begin
                t = t + 1;
                break;
            end
            if (w[31:26] != 6'd0) begin
                if (abort_c < 0 || t < abort_c) model_illegal++;
                t = t + 1;
            end else begin
                for (int c = t + 1; c <= MAXC; c++) begin
                    exp_iv[c] = 1'b1;
                    exp_word[c] = w;
                end
                exp_we[t+S+1] = 1'b1;
                if (abort_c < 0 || (t + S + 1) < abort_c) begin
                    model_issued++;
                    model_last = core_model(w);
                end
                t = t + S + 2;
            end
        end
        done_c = t;
        exp_done[done_c] = 1'b1;
        for (int c = 1; c <= done_c; c++) exp_busy[c] = 1'b1;
        for (int c = done_c + 1; c <= MAXC; c++) exp_iv[c] = 1'b0;
        end_c = done_c + 2;
        if (abort_c >= 0) begin
            for (int c = abort_c + 1; c <= MAXC; c++) begin
                exp_we[c] = 1'b0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0; exp_iv[c] = 1'b0;
            end
            end_c = abort_c + 8;
        end
    endtask

    // Per-cycle comparison against the model timeline
    always @(negedge clk) begin
        if (chk_en) begin
            chk("reg_we", {31'd0, reg_we}, {31'd0, exp_we[drv_cyc]});
            chk("done", {31'd0, done}, {31'd0, exp_done[drv_cyc]});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy[drv_cyc]});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_iv[drv_cyc]});
            if (exp_iv[drv_cyc]) chk("instruction_set", instruction_set, exp_word[drv_cyc]);
            if (reg_we) we_seen++;
            if (done && dut_done_c < 0) dut_done_c = drv_cyc;
            if (forbid_en && instr_valid && instruction_set == forbid_word) forbid_hits++;
        end
    end

    task automatic load_word(input int a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic run_prog(input int plen, input int abort_c, input int poke_c, input string nm);
        int end_c;
        build_trace(plen, abort_c, end_c);
        we_seen = 0;
        dut_done_c = -1;
        prog_len = (AW+1)'(plen);
        for (int c = 0; c <= end_c; c++) begin
            drv_cyc   = c;
            start     = (c == 0) || (c == poke_c);
            abort     = (c == abort_c);
            load_en   = (c == poke_c);
            load_addr = '0;
            load_data = 32'h1234_5678;
            chk_en    = 1'b1;
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        start = 1'b0; abort = 1'b0; load_en = 1'b0;
        chk({nm, "_issued"}, {27'd0, issued_count}, model_issued);
        chk({nm, "_illegal"}, {27'd0, illegal_count}, model_illegal);
        chk({nm, "_last_result"}, last_result, model_last);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; start = 1'b0; abort = 1'b0;
        load_addr = '0; load_data = 32'd0; prog_len = '0;
        forbid_word = 32'd0; forbid_hits = 0;

        // Reset held two cycles: every output low
        @(posedge clk); @(posedge clk); #1;
        chk("rst_instruction_set", instruction_set, 32'd0);
        chk("rst_flags", {28'd0, instr_valid, reg_we, busy, done}, 32'd0);
        chk("rst_last_result", last_result, 32'd0);
        chk("rst_counts", {22'd0, issued_count, illegal_count}, 32'd0);
        reset = 1'b0;

        // Zero-length program
        run_prog(0, -1, -1, "len0");
        chk("len0_done_cycle", dut_done_c, 32'd1);
        chk("len0_we_count", we_seen, 32'd0);

        // Three legal words
        load_word(0, L1); load_word(1, L2); load_word(2, L3);
        run_prog(3, -1, -1, "normal");
        chk("normal_done_cycle", dut_done_c, 32'd13);
        chk("normal_we_count", we_seen, 32'd3);
        chk("normal_issued_lit", {27'd0, issued_count}, 32'd3);
        chk("normal_last_lit", last_result, 32'h0000_010C);

        // Illegal opcode and halt sentinel; fifth word must never appear
        load_word(0, L1); load_word(1, BAD); load_word(2, L4);
        load_word(3, HALT); load_word(4, L3);
        forbid_en = 1'b1; forbid_word = L3; forbid_hits = 0;
        run_prog(5, -1, -1, "halt");
        forbid_en = 1'b0;
        chk("halt_done_cycle", dut_done_c, 32'd11);
        chk("halt_issued_lit", {27'd0, issued_count}, 32'd2);
        chk("halt_illegal_lit", {27'd0, illegal_count}, 32'd1);
        chk("halt_last_lit", last_result, 32'h0000_0107);
        chk("halt_word5_shown", forbid_hits, 32'd0);

        // Abort during SETTLE of the second instruction
        load_word(1, L2); load_word(2, L3);
        run_prog(3, 6, -1, "abort");
        chk("abort_we_count", we_seen, 32'd1);
        chk("abort_no_done", dut_done_c, 32'hFFFF_FFFF);
        chk("abort_issued_lit", {27'd0, issued_count}, 32'd1);
        chk("abort_last_lit", last_result, 32'h0000_0103);

        // start/load pulsed mid-run are ignored; buf[0] still holds L1
        run_prog(2, -1, 3, "ignore");
        chk("ignore_done_cycle", dut_done_c, 32'd9);
        run_prog(1, -1, -1, "readback");
        chk("readback_last_lit", last_result, 32'h0000_0103);

        // Full buffer, prog_len above DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, {6'd0, 5'(i), 5'(i + 1), 5'd2, 5'd0, 6'h20});
        end
        run_prog(DEPTH + 1, -1, -1, "full");
        chk("full_done_cycle", dut_done_c, 32'd65);
        chk("full_we_count", we_seen, 32'd16);
        chk("full_issued_lit", {27'd0, issued_count}, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
